// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit seven-segment driver with hex decode,
// per-digit blanking/decimal point and frame-boundary (tear-free) value update.
`default_nettype none

module seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
    localparam logic          INV       = (ACTIVE_LOW != 0);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  boundary;

    logic [4*DIGITS-1:0]   pend_value;
    logic [DIGITS-1:0]     pend_blank;
    logic [DIGITS-1:0]     pend_dp;
    logic [4*DIGITS-1:0]   act_value;
    logic [DIGITS-1:0]     act_blank;
    logic [DIGITS-1:0]     act_dp;

    logic [3:0]            sel_nib;
    logic                  sel_blank;
    logic                  sel_dp;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [DIGITS-1:0]     an_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick     = (presc == PRESC_MAX);
    assign boundary = tick && (idx == IDX_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
        end
    end

    // A load landing on the boundary tick bypasses pending so it shows in the very next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_value <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            act_value  <= '0;
            act_blank  <= '1;
            act_dp     <= '0;
        end else begin
            if (load) begin
                pend_value <= value;
                pend_blank <= blank_mask;
                pend_dp    <= dp_in;
            end
            if (boundary) begin
                act_value <= load ? value      : pend_value;
                act_blank <= load ? blank_mask : pend_blank;
                act_dp    <= load ? dp_in      : pend_dp;
            end
        end
    end

    always_comb begin
        sel_nib   = '0;
        sel_blank = 1'b1;
        sel_dp    = 1'b0;
        an_next   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                sel_nib   = act_value[4*k +: 4];
                sel_blank = act_blank[k];
                sel_dp    = act_dp[k];
                an_next[k] = 1'b1;
            end
        end
        seg_next = sel_blank ? 7'h00 : hex7(sel_nib);
        dp_next  = !sel_blank && sel_dp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= {7{INV}};
            dp         <= INV;
            an         <= {DIGITS{INV}};
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next ^ {7{INV}};
            dp         <= dp_next ^ INV;
            an         <= an_next ^ {DIGITS{INV}};
            frame_done <= boundary;
        end
    end

endmodule

`default_nettype wire
